module_0: RTL and testbench
===========================

# module_0

First processing stage of the 512-point, 16-lane parallel FFT pipeline. It accepts one complex frame of 512 samples as 32 blocks of 16 lanes. It performs the first two radix-2² decimation-in-frequency butterfly steps (span 256, trivial −j twiddle, span 128) and emits the results as 11-bit blocks in natural index order to the next stage.

## Interface
- No parameters. Widths are fixed: input 9 bits, output 11 bits, 16 lanes, 512 points.
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: reset, synchronous, active-high (asserted when 1).
- `din_valid` in 1: input block qualifier.
- `din_i[0:15]`, `din_q[0:15]` in 16×9 signed: real and imaginary lanes.
- `valid_out` out 1: output block qualifier.
- `module0_dout_i[0:15]`, `module0_dout_q[0:15]` out 16×11 signed: real and imaginary output lanes.

## Operation
- Sample index mapping: n = 16·c + j, where c is the block index 0..31 and j is the lane. This mapping applies to both input and output.
- Input block index counter (5-bit):
  - Increments on each clock with `din_valid`=1.
  - Wraps 31→0.
  - The 32 blocks of a frame must arrive on consecutive valid cycles.
  - Idle gaps of any length are allowed between frames.
- Step A, span 256, 10-bit result:
  - For n<256: a[n] = x[n] + x[n+256]; a[n+256] = x[n] − x[n+256].
- Twiddle:
  - For 384 ≤ n < 512: a'[n] = −j·a[n], i.e. (re, im) → (im, −re).
  - Otherwise a'[n] = a[n].
- Step B, span 128 within each 256-half h ∈ {0, 256}, 11-bit result, for k<128:
  - b[h+k] = a'[h+k] + a'[h+k+128]
  - b[h+k+128] = a'[h+k] − a'[h+k+128]
- Output b[n] at index position n. Arithmetic is full precision: sign-extend before each add or subtract, with no rounding, truncation or saturation.
- Structure: two single-delay-feedback sections with a per-block tag (block index, valid) carried alongside the data.
  - Section A uses a 16-block delay line.
    - When a valid block with index ≥16 arrives, the section emits the sum and pushes the difference.
    - Otherwise it emits the delay-line head and pushes the input.
  - Section B is the same with an 8-block delay line, keyed on index bit 3.
  - Delay lines shift every clock, so tail data flushes without further input.
- `valid_out` is the tag valid bit at the output register.

## Timing
- Latency: output block c appears exactly 26 clocks after input block c is sampled.
  - Section A contributes 16 + 1 register.
  - Section B contributes 8 + 1 register.
- Back-to-back frames: `valid_out` stays high for 64 consecutive cycles, with no bubble between frames.
- An idle gap between input frames is reproduced unchanged at the output.
- Reset:
  - Clears the block counter, all tag valid bits, all output registers and `valid_out` to 0 on the next edge.
  - Delay-line data need not be cleared.
  - Reset mid-frame discards the partial frame; no `valid_out` is produced for it.
  - A new frame may start on the first cycle after reset deasserts.
- A `din_valid` drop mid-frame is a protocol violation. Output data for that frame is unspecified, but the tags still drive `valid_out`.

## Configuration
- `MODULE0_ZERO_INVALID_EN`
  - Defined: output data lanes are forced to 0 on every cycle where `valid_out`=0.
  - Undefined: output data lanes show raw pipeline contents when `valid_out`=0.
- Valid data, latency and `valid_out` are identical in both builds.

## Test plan
- Impulse test:
  - Stimulus: x[0] = 1+j0, all other samples 0.
  - Required: output blocks 0, 8, 16 and 24, lane 0, each = 1+j0; all other outputs 0.
  - Required: first `valid_out` exactly 26 clocks after block 0 is sampled.
- Twiddle check:
  - Stimulus: x[384] = 1+j0, all others 0.
  - Required: b[0] = 1, b[128] = −1, b[256] = 0+j1, b[384] = 0−j1; all others 0.
- Negative full scale:
  - Stimulus: every sample −256−j256.
  - Required: b[0..127] = −1024−j1024; b[128..511] = 0.
- Positive full scale:
  - Stimulus: every sample 255+j255.
  - Required: b[0..127] = 1020+j1020; all others 0.
- Frame spacing:
  - Stimulus: two back-to-back frames, then a third frame after a 10-cycle idle gap.
  - Required: `valid_out` high for 64 cycles, low for 10, then high for 32.
  - Required: each frame's results match the reference model.
- Reset mid-frame:
  - Stimulus: assert `rstn` at input block 12, then send a full frame.
  - Required: `valid_out`=0 and outputs 0 the cycle after reset.
  - Required: only the new frame appears, 26 clocks after its block 0.

Source files
------------

// File: rtl/module_0.sv
// First 512-point FFT stage: two radix-2^2 DIF butterfly steps (span 256, -j twiddle, span 128)
// as single-delay-feedback sections. Build option MODULE0_ZERO_INVALID_EN zeroes data lanes when not valid.
module module_0 (
  input  logic              clk,
  input  logic              rstn,
  input  logic              din_valid,
  input  logic signed [8:0] din_i [0:15],
  input  logic signed [8:0] din_q [0:15],
  output logic              valid_out,
  output logic signed [10:0] module0_dout_i [0:15],
  output logic signed [10:0] module0_dout_q [0:15]
);

  localparam int unsigned LANES   = 16;
  localparam int unsigned IN_W    = 9;
  localparam int unsigned A_W     = 10;
  localparam int unsigned OUT_W   = 11;
  localparam int unsigned A_DEPTH = 16;
  localparam int unsigned B_DEPTH = 8;
  localparam int unsigned IDX_W   = 5;

  // Input register stage with block counter; tag keeps only the two index bits the sections need
  logic [IDX_W-1:0]       cnt_q;
  logic                   in_vld_q;
  logic [1:0]             in_hi_q;
  logic signed [IN_W-1:0] in_re_q [LANES];
  logic signed [IN_W-1:0] in_im_q [LANES];

  always_ff @(posedge clk) begin : p_in_ctrl
    if (rstn) begin
      cnt_q    <= '0;
      in_vld_q <= 1'b0;
      in_hi_q  <= '0;
    end else begin
      in_vld_q <= din_valid;
      in_hi_q  <= cnt_q[IDX_W-1 -: 2];
      if (din_valid) cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin : p_in_data
    for (int unsigned l = 0; l < LANES; l++) begin
      in_re_q[l] <= din_i[l];
      in_im_q[l] <= din_q[l];
    end
  end

  // Section A: span-256 butterfly around a 16-block delay line
  logic signed [A_W-1:0] a_dl_re_q [A_DEPTH][LANES];
  logic signed [A_W-1:0] a_dl_im_q [A_DEPTH][LANES];
  logic [1:0]            a_dl_hi_q [A_DEPTH];
  logic [A_DEPTH-1:0]    a_dl_vld_q;
  logic signed [A_W-1:0] a_emit_re_d [LANES];
  logic signed [A_W-1:0] a_emit_im_d [LANES];
  logic signed [A_W-1:0] a_push_re_d [LANES];
  logic signed [A_W-1:0] a_push_im_d [LANES];
  logic                  a_fly;

  always_comb begin : p_a_fly
    a_fly = in_vld_q & in_hi_q[1];
    for (int unsigned l = 0; l < LANES; l++) begin
      a_emit_re_d[l] = a_dl_re_q[A_DEPTH-1][l];
      a_emit_im_d[l] = a_dl_im_q[A_DEPTH-1][l];
      a_push_re_d[l] = A_W'(in_re_q[l]);
      a_push_im_d[l] = A_W'(in_im_q[l]);
      if (a_fly) begin
        a_emit_re_d[l] = a_dl_re_q[A_DEPTH-1][l] + A_W'(in_re_q[l]);
        a_emit_im_d[l] = a_dl_im_q[A_DEPTH-1][l] + A_W'(in_im_q[l]);
        a_push_re_d[l] = a_dl_re_q[A_DEPTH-1][l] - A_W'(in_re_q[l]);
        a_push_im_d[l] = a_dl_im_q[A_DEPTH-1][l] - A_W'(in_im_q[l]);
      end
    end
  end

  always_ff @(posedge clk) begin : p_a_dl_data
    a_dl_re_q[0] <= a_push_re_d;
    a_dl_im_q[0] <= a_push_im_d;
    a_dl_hi_q[0] <= in_hi_q;
    for (int unsigned s = 1; s < A_DEPTH; s++) begin
      a_dl_re_q[s] <= a_dl_re_q[s-1];
      a_dl_im_q[s] <= a_dl_im_q[s-1];
      a_dl_hi_q[s] <= a_dl_hi_q[s-1];
    end
  end

  always_ff @(posedge clk) begin : p_a_dl_vld
    if (rstn) a_dl_vld_q <= '0;
    else      a_dl_vld_q <= {a_dl_vld_q[A_DEPTH-2:0], in_vld_q};
  end

  logic signed [A_W-1:0] a_re_q [LANES];
  logic signed [A_W-1:0] a_im_q [LANES];
  logic [1:0]            a_hi_q;
  logic                  a_vld_q;

  always_ff @(posedge clk) begin : p_a_out
    a_re_q <= a_emit_re_d;
    a_im_q <= a_emit_im_d;
    if (rstn) begin
      a_vld_q <= 1'b0;
      a_hi_q  <= '0;
    end else begin
      a_vld_q <= a_dl_vld_q[A_DEPTH-1];
      a_hi_q  <= a_dl_hi_q[A_DEPTH-1];
    end
  end

  // Twiddle on blocks 24..31, then section B: span-128 butterfly around an 8-block delay line
  logic signed [OUT_W-1:0] b_dl_re_q [B_DEPTH][LANES];
  logic signed [OUT_W-1:0] b_dl_im_q [B_DEPTH][LANES];
  logic [B_DEPTH-1:0]      b_dl_vld_q;
  logic signed [A_W-1:0]   tw_re [LANES];
  logic signed [A_W-1:0]   tw_im [LANES];
  logic signed [OUT_W-1:0] b_emit_re_d [LANES];
  logic signed [OUT_W-1:0] b_emit_im_d [LANES];
  logic signed [OUT_W-1:0] b_push_re_d [LANES];
  logic signed [OUT_W-1:0] b_push_im_d [LANES];
  logic                    b_fly;

  always_comb begin : p_b_fly
    b_fly = a_vld_q & a_hi_q[0];
    for (int unsigned l = 0; l < LANES; l++) begin
      tw_re[l] = a_re_q[l];
      tw_im[l] = a_im_q[l];
      if (a_hi_q == 2'b11) begin
        tw_re[l] = a_im_q[l];
        tw_im[l] = -a_re_q[l];
      end
      b_emit_re_d[l] = b_dl_re_q[B_DEPTH-1][l];
      b_emit_im_d[l] = b_dl_im_q[B_DEPTH-1][l];
      b_push_re_d[l] = OUT_W'(tw_re[l]);
      b_push_im_d[l] = OUT_W'(tw_im[l]);
      if (b_fly) begin
        b_emit_re_d[l] = b_dl_re_q[B_DEPTH-1][l] + OUT_W'(tw_re[l]);
        b_emit_im_d[l] = b_dl_im_q[B_DEPTH-1][l] + OUT_W'(tw_im[l]);
        b_push_re_d[l] = b_dl_re_q[B_DEPTH-1][l] - OUT_W'(tw_re[l]);
        b_push_im_d[l] = b_dl_im_q[B_DEPTH-1][l] - OUT_W'(tw_im[l]);
      end
    end
  end

  always_ff @(posedge clk) begin : p_b_dl_data
    b_dl_re_q[0] <= b_push_re_d;
    b_dl_im_q[0] <= b_push_im_d;
    for (int unsigned s = 1; s < B_DEPTH; s++) begin
      b_dl_re_q[s] <= b_dl_re_q[s-1];
      b_dl_im_q[s] <= b_dl_im_q[s-1];
    end
  end

  always_ff @(posedge clk) begin : p_b_dl_vld
    if (rstn) b_dl_vld_q <= '0;
    else      b_dl_vld_q <= {b_dl_vld_q[B_DEPTH-2:0], a_vld_q};
  end

  always_ff @(posedge clk) begin : p_out
    if (rstn) begin
      valid_out <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        module0_dout_i[l] <= '0;
        module0_dout_q[l] <= '0;
      end
    end else begin
      valid_out <= b_dl_vld_q[B_DEPTH-1];
      for (int unsigned l = 0; l < LANES; l++) begin
`ifdef MODULE0_ZERO_INVALID_EN
        module0_dout_i[l] <= b_dl_vld_q[B_DEPTH-1] ? b_emit_re_d[l] : '0;
        module0_dout_q[l] <= b_dl_vld_q[B_DEPTH-1] ? b_emit_im_d[l] : '0;
`else
        module0_dout_i[l] <= b_emit_re_d[l];
        module0_dout_q[l] <= b_emit_im_d[l];
`endif
      end
    end
  end

endmodule

// File: tb/tb_module_0.sv
// Bench for module_0: directed and random frames checked against a frame-level butterfly model.
module tb_module_0;

  localparam int LANES = 16;
  localparam int NPTS  = 512;
  localparam int NBLK  = 32;
  localparam int LAT   = 26;
  localparam int MAXC  = 1024;

  logic clk = 1'b0;
  logic rstn;
  logic din_valid;
  logic signed [8:0]  din_i [0:15];
  logic signed [8:0]  din_q [0:15];
  logic valid_out;
  logic signed [10:0] dout_i [0:15];
  logic signed [10:0] dout_q [0:15];

  module_0 dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
    .valid_out(valid_out), .module0_dout_i(dout_i), .module0_dout_q(dout_q)
  );

  always #5 clk = ~clk;

  int x_re [NPTS];
  int x_im [NPTS];
  int b_re [NPTS];
  int b_im [NPTS];
  bit exp_vld  [MAXC];
  bit exp_zero [MAXC];
  int exp_re [MAXC][LANES];
  int exp_im [MAXC][LANES];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [10:0] obs, input logic signed [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Frame-level reference: span-256 butterfly, -j twiddle on the top quarter, span-128 butterflies
  task automatic ref_model();
    int a_re [NPTS];
    int a_im [NPTS];
    int t;
    for (int n = 0; n < 256; n++) begin
      a_re[n]     = x_re[n] + x_re[n+256];
      a_im[n]     = x_im[n] + x_im[n+256];
      a_re[n+256] = x_re[n] - x_re[n+256];
      a_im[n+256] = x_im[n] - x_im[n+256];
    end
    for (int n = 384; n < 512; n++) begin
      t       = a_re[n];
      a_re[n] = a_im[n];
      a_im[n] = -t;
    end
    for (int h = 0; h < 512; h += 256) begin
      for (int k = 0; k < 128; k++) begin
        b_re[h+k]     = a_re[h+k] + a_re[h+k+128];
        b_im[h+k]     = a_im[h+k] + a_im[h+k+128];
        b_re[h+k+128] = a_re[h+k] - a_re[h+k+128];
        b_im[h+k+128] = a_im[h+k] - a_im[h+k+128];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("valid_out", {10'd0, valid_out}, {10'd0, exp_vld[cyc]});
    if (exp_vld[cyc] || exp_zero[cyc]) begin
      for (int l = 0; l < LANES; l++) begin
        chk($sformatf("dout_i[%0d]", l), dout_i[l], 11'(exp_re[cyc][l]));
        chk($sformatf("dout_q[%0d]", l), dout_q[l], 11'(exp_im[cyc][l]));
      end
    end
    cyc++;
    if (cyc + LAT >= MAXC) begin
      $display("FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, MAXC - LAT);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // Reset discards everything in flight; output must read zero/invalid right after
  task automatic apply_reset();
    rstn = 1'b1;
    for (int k = cyc; k < cyc + LAT; k++) exp_vld[k] = 1'b0;
    exp_zero[cyc] = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      exp_re[cyc][l] = 0;
      exp_im[cyc][l] = 0;
    end
    tick();
    rstn = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      for (int j = 0; j < LANES; j++) begin
        din_i[j] = 9'($urandom);
        din_q[j] = 9'($urandom);
      end
      tick();
    end
  endtask

  // kind: 0 random, 1 impulse at 0, 2 impulse at 384, 3 negative full scale, 4 positive full scale
  task automatic fill(input int kind);
    for (int n = 0; n < NPTS; n++) begin
      case (kind)
        0:       begin x_re[n] = int'($urandom_range(511)) - 256; x_im[n] = int'($urandom_range(511)) - 256; end
        1:       begin x_re[n] = (n == 0) ? 1 : 0;   x_im[n] = 0; end
        2:       begin x_re[n] = (n == 384) ? 1 : 0; x_im[n] = 0; end
        3:       begin x_re[n] = -256; x_im[n] = -256; end
        default: begin x_re[n] = 255;  x_im[n] = 255;  end
      endcase
    end
  endtask

  // Send one frame; if rst_blk is in range, reset is asserted together with that block
  task automatic send_frame(input int rst_blk);
    ref_model();
    for (int c = 0; c < NBLK; c++) begin
      din_valid = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        din_i[j] = 9'(x_re[16*c+j]);
        din_q[j] = 9'(x_im[16*c+j]);
      end
      if (c == rst_blk) begin
        apply_reset();
        din_valid = 1'b0;
        return;
      end
      exp_vld[cyc+LAT] = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        exp_re[cyc+LAT][j] = b_re[16*c+j];
        exp_im[cyc+LAT][j] = b_im[16*c+j];
      end
      tick();
    end
    din_valid = 1'b0;
  endtask

  initial begin
    rstn      = 1'b1;
    din_valid = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      din_i[j] = '0;
      din_q[j] = '0;
    end
    apply_reset();
    idle(2);

    fill(1); send_frame(-1); idle(30);
    fill(2); send_frame(-1); idle(5);

    // Two back-to-back frames, 10-cycle gap, third frame
    fill(3); send_frame(-1);
    fill(4); send_frame(-1);
    idle(10);
    fill(0); send_frame(-1); idle(30);

    fill(0); send_frame(-1);
    fill(0); send_frame(-1); idle(30);

    // Reset at block 12, new frame immediately after
    fill(0); send_frame(12);
    fill(0); send_frame(-1); idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
